// File: rtl/neighbor_stream_requester.sv
// Edge-PE-side endpoint of the neighbor-list protocol.
// Takes one lookup at a time from the PE and pushes a single request into the
// shared neighbor request FIFO. It captures the returned sos/eos ID stream into
// a local buffer and hands the IDs back to the PE over valid/ready. Because the
// stream has no backpressure, a request is accepted only when the buffer has
// room for a maximum-length list.
module neighbor_stream_requester #(
  parameter int                ADDR_W    = 10,
  parameter int                ID_W      = 14,
  parameter int                ITER_W    = 4,
  parameter int                TAG_W     = 2,
  parameter logic [TAG_W-1:0]  PE_TAG    = '0,
  parameter int                BUF_DEPTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              wdata_valid,
  output logic [ADDR_W-1:0] wdata_addr,
  output logic [TAG_W-1:0]  wdata_PE_tag,
  input  logic              wfull,
  input  logic              nb_sos,
  input  logic              nb_eos,
  input  logic [ITER_W-1:0] nb_num_iter,
  input  logic [ID_W-1:0]   nb_id,
  output logic              id_valid,
  output logic [ID_W-1:0]   id_data,
  output logic              id_last,
  input  logic              id_ready,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W    = $clog2(BUF_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  // Two spare bits let an over-long stream count past num_iter+1 before saturating.
  localparam int BEAT_W   = ITER_W + 2;
  localparam int MAX_LIST = 1 << ITER_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RECV} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [ITER_W-1:0]   num_iter_q;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [BEAT_W-1:0]   beat_next;
  logic                err_q;

  // Buffer entries are {last, id}.
  logic [ID_W:0]       mem [BUF_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    free_cnt;

  logic                wr_en;
  logic                wr_last;
  logic                wr_ok;
  logic                rd_en;
  logic                buf_full;
  logic                proto_err;
  logic                len_err;

  assign free_cnt  = CNT_W'(BUF_DEPTH) - count;
  assign buf_full  = (count == CNT_W'(BUF_DEPTH));
  assign rd_en     = id_ready && (count != '0);
  assign wr_ok     = wr_en && !buf_full;

  // A new lookup is accepted only if a maximum-length list is guaranteed to fit.
  assign req_ready    = (state == IDLE) && (free_cnt >= CNT_W'(MAX_LIST));
  assign wdata_valid  = (state == ISSUE) && !wfull;
  assign wdata_addr   = addr_q;
  assign wdata_PE_tag = PE_TAG;
  assign id_valid     = (count != '0);
  assign id_data      = mem[rd_ptr][ID_W-1:0];
  assign id_last      = mem[rd_ptr][ID_W];
  assign busy         = (state != IDLE);
  assign err          = err_q;

  // Classify the current stream beat: buffer write, last marker, protocol and length errors.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    wr_en     = 1'b0;
    wr_last   = 1'b0;
    proto_err = 1'b0;
    len_err   = 1'b0;
    beat_next = beat_cnt;
    case (state)
      IDLE, ISSUE: begin
        proto_err = nb_sos || nb_eos;
      end
      WAIT: begin
        if (nb_sos) begin
          wr_en     = 1'b1;
          wr_last   = nb_eos;
          beat_next = BEAT_W'(1);
          len_err   = nb_eos && (nb_num_iter != '0);
        end else if (nb_eos) begin
          proto_err = 1'b1;
        end
      end
      RECV: begin
        wr_en     = 1'b1;
        wr_last   = nb_eos;
        proto_err = nb_sos;
        beat_next = (beat_cnt == '1) ? beat_cnt : beat_cnt + BEAT_W'(1);
        len_err   = nb_eos && (beat_next != BEAT_W'(num_iter_q) + BEAT_W'(1));
      end
      default: begin
        proto_err = 1'b0;
      end
    endcase
  end

  // Request/stream FSM: accept lookup, push one request, then receive one list.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state      <= IDLE;
      addr_q     <= '0;
      num_iter_q <= '0;
      beat_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q <= req_addr;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          if (!wfull) state <= WAIT;
        end
        WAIT: begin
          if (nb_sos) begin
            num_iter_q <= nb_num_iter;
            beat_cnt   <= beat_next;
            state      <= nb_eos ? IDLE : RECV;
          end
        end
        RECV: begin
          beat_cnt <= beat_next;
          if (nb_eos) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer pointers and occupancy; a write into a full buffer is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_ok, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage; entries are only read after being written, so no reset is needed.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately left out of reset; count gates every read.
    if (wr_ok) mem[wr_ptr] <= {wr_last, nb_id};
  end

  // Sticky error flag covering stray markers, length mismatches and overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (proto_err || len_err || (wr_en && buf_full)) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_neighbor_stream_requester.sv
// Self-checking bench for neighbor_stream_requester: directed steps plus
// randomized lists, compared against a protocol-level queue model.
module tb_neighbor_stream_requester;

  localparam int               ADDR_W    = 10;
  localparam int               ID_W      = 14;
  localparam int               ITER_W    = 4;
  localparam int               TAG_W     = 2;
  localparam logic [TAG_W-1:0] PE_TAG    = 2'd2;
  localparam int               BUF_DEPTH = 32;
  localparam int               MAX_LIST  = 1 << ITER_W;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              wdata_valid;
  logic [ADDR_W-1:0] wdata_addr;
  logic [TAG_W-1:0]  wdata_PE_tag;
  logic              wfull;
  logic              nb_sos;
  logic              nb_eos;
  logic [ITER_W-1:0] nb_num_iter;
  logic [ID_W-1:0]   nb_id;
  logic              id_valid;
  logic [ID_W-1:0]   id_data;
  logic              id_last;
  logic              id_ready;
  logic              busy;
  logic              err;

  neighbor_stream_requester #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .ITER_W(ITER_W), .TAG_W(TAG_W),
    .PE_TAG(PE_TAG), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .wdata_valid(wdata_valid), .wdata_addr(wdata_addr), .wdata_PE_tag(wdata_PE_tag),
    .wfull(wfull),
    .nb_sos(nb_sos), .nb_eos(nb_eos), .nb_num_iter(nb_num_iter), .nb_id(nb_id),
    .id_valid(id_valid), .id_data(id_data), .id_last(id_last), .id_ready(id_ready),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: queue of expected {last,id} entries plus the request/list progress.
  logic [ID_W:0]     mq[$];
  bit                m_pending;   // accepted, not yet pushed
  bit                m_awaiting;  // pushed, waiting for sos
  bit                m_in_list;   // between sos and eos
  bit                m_err;
  int                m_beats;
  int                m_target;
  logic [ADDR_W-1:0] m_addr;
  int                rdy_mode;    // 0: never consume, 1: always, 2: random

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pending  = 0;
    m_awaiting = 0;
    m_in_list  = 0;
    m_err      = 0;
    m_beats    = 0;
    m_target   = 0;
    m_addr     = '0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input bit rv, input logic [ADDR_W-1:0] ra, input bit wf,
                       input bit sos, input bit eos, input logic [ITER_W-1:0] ni,
                       input logic [ID_W-1:0] id);
    bit            m_idle, m_ready, pop, wr, rdy;
    logic [ID_W:0] ent;
    rdy = (rdy_mode == 2) ? bit'($urandom_range(0, 1)) : (rdy_mode == 1);
    req_valid = rv; req_addr = ra; wfull = wf;
    nb_sos = sos; nb_eos = eos; nb_num_iter = ni; nb_id = id; id_ready = rdy;
    #1;
    m_idle  = !(m_pending || m_awaiting || m_in_list);
    m_ready = m_idle && ((BUF_DEPTH - mq.size()) >= MAX_LIST);
    check("req_ready", req_ready, m_ready);
    check("wdata_valid", wdata_valid, m_pending && !wf);
    if (m_pending && !wf) begin
      check("wdata_addr", wdata_addr, m_addr);
      check("wdata_tag", wdata_PE_tag, PE_TAG);
    end
    check("busy", busy, !m_idle);
    check("err", err, m_err);
    check("id_valid", id_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("id_data", id_data, mq[0][ID_W-1:0]);
      check("id_last", id_last, mq[0][ID_W]);
    end
    pop = rdy && (mq.size() != 0);
    wr  = 0;
    ent = '0;
    if (m_awaiting) begin
      if (sos) begin
        wr = 1; ent = {eos, id};
        m_awaiting = 0;
        if (eos) begin
          if (ni != 0) m_err = 1;
        end else begin
          m_in_list = 1; m_beats = 1; m_target = int'(ni) + 1;
        end
      end else if (eos) begin
        m_err = 1;
      end
    end else if (m_in_list) begin
      wr = 1; ent = {eos, id};
      m_beats++;
      if (sos) m_err = 1;
      if (eos) begin
        if (m_beats != m_target) m_err = 1;
        m_in_list = 0;
      end
    end else if (sos || eos) begin
      m_err = 1;
    end
    if (wr && mq.size() == BUF_DEPTH) begin
      m_err = 1; wr = 0;
    end
    if (pop) void'(mq.pop_front());
    if (wr) mq.push_back(ent);
    if (m_pending && !wf) begin
      m_pending = 0; m_awaiting = 1;
    end else if (m_ready && rv) begin
      m_pending = 1; m_addr = ra;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, '0);
  endtask

  // Hold req_valid until accepted (bounded), then keep wfull high n_full cycles before the push.
  task automatic request(input logic [ADDR_W-1:0] addr, input int n_full);
    int guard = 0;
    while (!m_pending && guard < 200) begin
      cycle(1, addr, 0, 0, 0, '0, '0);
      guard++;
    end
    if (!m_pending) begin
      n_assert++; n_fail++;
      $error("FAIL req_accept_timeout: observed req_ready %0b expected acceptance within 200 cycles", req_ready);
    end
    for (int i = 0; i < n_full; i++) cycle(0, '0, 1, 0, 0, '0, '0);
    cycle(0, '0, 0, 0, 0, '0, '0);
  endtask

  // Send one contiguous list after `gap` quiet cycles; ids are base+i or random.
  task automatic send_list(input int len, input logic [ITER_W-1:0] ni, input int gap,
                           input bit rand_ids, input logic [ID_W-1:0] base);
    logic [ID_W-1:0] id;
    idle_cycles(gap);
    for (int i = 0; i < len; i++) begin
      id = rand_ids ? ID_W'($urandom) : base + ID_W'(i);
      cycle(0, '0, 0, i == 0, i == len - 1,
            (i == 0) ? ni : ITER_W'($urandom), id);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rdy_mode = 0;
    reset = 1'b1;
    req_valid = 0; req_addr = '0; wfull = 0; nb_sos = 0; nb_eos = 0;
    nb_num_iter = '0; nb_id = '0; id_ready = 0;
    #1;
    check("rst_wdata_valid", wdata_valid, 1'b0);
    check("rst_wdata_addr", wdata_addr, '0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Single request at 0x155, 3-beat list 7,8,9, then drain.
    request(10'h155, 0);
    send_list(3, 4'd2, 2, 0, 14'd7);
    idle_cycles(1);
    check("three_entries", mq.size(), 3);
    rdy_mode = 1;
    idle_cycles(4);

    // wfull held 5 cycles during ISSUE, then a 1-beat list with id 0x3FFF.
    request(10'h2AA, 5);
    send_list(1, 4'd0, 1, 0, 14'h3FFF);
    idle_cycles(3);

    // Randomized well-formed traffic with random consumption and FIFO-full stalls.
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) begin
      int len;
      len = $urandom_range(1, MAX_LIST);
      request(ADDR_W'($urandom), $urandom_range(0, 3));
      send_list(len, ITER_W'(len - 1), $urandom_range(0, 3), 1, '0);
    end
    rdy_mode = 1;
    idle_cycles(BUF_DEPTH + 2);

    // Credit gating: two maximum-length lists fill the buffer.
    rdy_mode = 0;
    request(10'h011, 0);
    send_list(MAX_LIST, ITER_W'(MAX_LIST - 1), 0, 1, '0);
    request(10'h022, 0);
    send_list(MAX_LIST, ITER_W'(MAX_LIST - 1), 0, 1, '0);
    idle_cycles(1);
    check("credit_full", req_ready, 1'b0);
    rdy_mode = 1;
    idle_cycles(1);
    rdy_mode = 0;
    idle_cycles(1);
    check("credit_after_one", req_ready, 1'b0);
    rdy_mode = 1;
    idle_cycles(MAX_LIST - 1);
    rdy_mode = 0;
    idle_cycles(1);
    check("credit_after_16", req_ready, 1'b1);
    rdy_mode = 1;
    idle_cycles(MAX_LIST + 2);

    // Length mismatch: num_iter=3 but only 2 beats.
    rdy_mode = 0;
    request(10'h0F0, 0);
    send_list(2, 4'd3, 1, 0, 14'h100);
    idle_cycles(1);
    check("mismatch_err", err, 1'b1);
    rdy_mode = 1;
    idle_cycles(3);

    // Reset during RECV after 2 beats of a 4-beat list.
    rdy_mode = 0;
    request(10'h3C3, 0);
    cycle(0, '0, 0, 1, 0, 4'd3, 14'h200);
    cycle(0, '0, 0, 0, 0, 4'd0, 14'h201);
    reset = 1'b1;
    #2;
    check("async_rst_busy", busy, 1'b0);
    check("async_rst_id_valid", id_valid, 1'b0);
    check("async_rst_err", err, 1'b0);
    check("async_rst_wdata_valid", wdata_valid, 1'b0);
    check("async_rst_wdata_addr", wdata_addr, '0);
    model_reset();
    reset = 1'b0;
    cycle(0, '0, 0, 0, 0, 4'd0, 14'h202);
    cycle(0, '0, 0, 0, 1, 4'd0, 14'h203);
    idle_cycles(1);
    check("stray_eos_err", err, 1'b1);
    rdy_mode = 1;
    request(10'h077, 1);
    send_list(2, 4'd1, 1, 0, 14'h300);
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/neighbor_stream_requester.md
Name: neighbor_stream_requester

Overview:
- Edge-PE-side endpoint of the neighbor-list protocol.
- Accepts a neighbor-list lookup from the PE compute logic and issues one request (valid/addr/PE_tag) into the shared neighbor request FIFO, honouring wfull.
- Captures the returned sos/eos neighbor-ID stream into a local buffer and presents it to the PE through a valid/ready interface.
- Checks stream length against Neighbor_num_Iter. One instance sits in front of each Edge PE.

Parameters:
- ADDR_W, 10, neighbor-info address width (Neighbor_info_bandwidth).
- ID_W, 14, neighbor ID width (Neighbor_ID_bandwidth).
- ITER_W, 4, width of Neighbor_num_Iter; max list length is 2^ITER_W beats.
- TAG_W, 2, PE tag width (clog2 of Num_Edge_PE).
- PE_TAG, 0, tag this instance places on every request.
- BUF_DEPTH, 32, local ID buffer entries (power of 2, at least 2^ITER_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- req_valid  in  1  PE requests the neighbor list at req_addr
- req_addr  in  ADDR_W  neighbor-info address
- req_ready  out  1  request accepted this cycle when req_valid is also high
- wdata_valid  out  1  push to neighbor request FIFO
- wdata_addr  out  ADDR_W  request address
- wdata_PE_tag  out  TAG_W  always PE_TAG
- wfull  in  1  neighbor request FIFO full
- nb_sos  in  1  stream start beat
- nb_eos  in  1  stream end beat
- nb_num_iter  in  ITER_W  on sos beat: total beats minus 1
- nb_id  in  ID_W  neighbor ID carried by the current beat
- id_valid  out  1  buffer non-empty
- id_data  out  ID_W  head neighbor ID
- id_last  out  1  head entry is the final ID of its list
- id_ready  in  1  PE consumes head
- busy  out  1  state is not IDLE
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, active-high) forces:
  - state to IDLE; buffer pointers and count to 0;
  - beat counter to 0; err=0;
  - wdata_valid=0, wdata_addr=0, id_valid=0, busy=0.
- Stream definition:
  - One ID per cycle, contiguous, from the sos cycle through the eos cycle inclusive.
  - sos and eos are both high on the same cycle for a 1-beat list.
  - No backpressure exists on the stream, so buffer space is reserved before a request is issued.
- FSM states: IDLE, ISSUE, WAIT, RECV.
- IDLE:
  - req_ready = (BUF_DEPTH - count) >= 2^ITER_W.
  - On req_valid&&req_ready: latch req_addr and go to ISSUE.
- ISSUE:
  - wdata_valid = !wfull, combinational; wdata_addr = latched address.
  - If !wfull, go to WAIT in the same cycle. Exactly one push per request.
  - If wfull, hold ISSUE indefinitely.
- WAIT:
  - On nb_sos: write nb_id to the buffer, latch nb_num_iter, and set the beat counter to 1.
  - If nb_eos is also high: perform the length check and go to IDLE. Otherwise go to RECV.
  - nb_eos without nb_sos in WAIT: set err, drop the beat, stay in WAIT.
- RECV:
  - Every cycle: write nb_id and increment the beat counter.
  - On nb_eos: perform the length check, mark the entry last, and go to IDLE.
  - nb_sos in RECV: set err; treat the beat as data.
- Length check: if the beat count including the eos beat is not latched num_iter+1, set err. Data is still delivered.
- Stray nb_sos/nb_eos in IDLE or ISSUE: ignored and set err.
- Buffer:
  - Entries are {last, id}. Write happens on the beat's clock edge.
  - id_valid=(count!=0) and id_data/id_last come from the head entry, so a beat at cycle T is visible at T+1.
  - Simultaneous write and read: count unchanged, both pointers advance.
  - Pointers wrap modulo BUF_DEPTH.
  - A write while full is dropped and sets err; the credit rule makes this reachable only on a protocol violation.
- Latency: req accepted at cycle T gives wdata_valid at T+1 if wfull=0.
- err: sticky until reset.
- Reset mid-stream: subsequent beats of that stream arrive in IDLE and flag err.

Test Plan:
- Single request, addr=0x155, wfull=0: wdata_valid one cycle at T+1 with addr 0x155, tag PE_TAG. Stream of 3 beats (num_iter=2, ids 7,8,9) appears on id_data in order, with id_last on 9; err=0.
- wfull held high 5 cycles during ISSUE: no push. Push occurs in the first cycle wfull=0; req_ready stays 0 throughout.
- 1-beat list (sos=eos, num_iter=0, id=0x3FFF): one entry with id_last=1; FSM returns to IDLE next cycle.
- Length mismatch: num_iter=3 but eos on beat 2 → err=1, 2 IDs delivered, the second with id_last=1.
- Credit gating: id_ready=0, two 16-beat lists fill BUF_DEPTH=32 → req_ready=0. Draining one entry keeps req_ready=0; draining 16 entries raises req_ready.
- Assert reset during RECV after 2 beats: outputs return to reset values asynchronously. Remaining beats set err. A new request then succeeds.
